// File: rtl/bf16_mac_seq_pkg.sv
// Shared bf16 constants, sequencer state encoding and a small normalisation helper.
package bf16_mac_seq_pkg;

    localparam logic [15:0] BF16_PZERO    = 16'h0000;
    localparam logic [15:0] BF16_PINF     = 16'h7F80;
    localparam logic [15:0] BF16_NINF     = 16'hFF80;
    localparam logic [15:0] BF16_QNAN     = 16'h7FC0;
    localparam int          BF16_EXP_BIAS = 127;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } seq_state_t;

    // Leading-zero count of an 11-bit significand; returns 11 for zero.
    function automatic logic [3:0] lzc11(input logic [10:0] v);
        logic [3:0] n;
        n = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (v[i]) n = 4'(10 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/bf16_add.sv
// Combinational bf16 adder: RNE, flush-to-zero subnormals, saturate to inf, canonical qNaN.
module bf16_add
    import bf16_mac_seq_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              big_s;
    logic [7:0]        big_e, sml_e, d;
    logic [6:0]        big_f, sml_f;
    logic [10:0]       big_m, sml_m, sml_sh, lost, diff, norm;
    logic [11:0]       tot;
    logic [3:0]        lz;
    logic signed [9:0] e;
    logic [7:0]        fr;
    logic              rnd;
    logic [15:0]       gen;

    always_comb begin
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
        a_zero = (a[14:7] == 8'h00);
        b_zero = (b[14:7] == 8'h00);

        if (a[14:0] >= b[14:0]) begin
            big_s = a[15]; big_e = a[14:7]; big_f = a[6:0];
            sml_e = b[14:7]; sml_f = b[6:0];
        end else begin
            big_s = b[15]; big_e = b[14:7]; big_f = b[6:0];
            sml_e = a[14:7]; sml_f = a[6:0];
        end

        d      = big_e - sml_e;
        big_m  = {1'b1, big_f, 3'b000};
        sml_m  = {1'b1, sml_f, 3'b000};
        sml_sh = 11'd0;
        lost   = 11'd0;
        if (d >= 8'd11) begin
            sml_sh = 11'd1;
        end else begin
            sml_sh    = sml_m >> d;
            lost      = sml_m & ((11'd1 << d) - 11'd1);
            sml_sh[0] = sml_sh[0] | (|lost);
        end

        tot  = 12'd0;
        diff = 11'd0;
        lz   = 4'd0;
        norm = 11'd0;
        e    = $signed({2'b00, big_e});
        if (a[15] == b[15]) begin
            tot = {1'b0, big_m} + {1'b0, sml_sh};
            if (tot[11]) begin
                norm    = tot[11:1];
                norm[0] = norm[0] | tot[0];
                e       = e + 10'sd1;
            end else begin
                norm = tot[10:0];
            end
        end else begin
            diff = big_m - sml_sh;
            lz   = lzc11(diff);
            norm = diff << lz;
            e    = e - $signed({6'b000000, lz});
        end

        // guard=norm[2], round=norm[1], sticky=norm[0], lsb=norm[3]
        rnd = norm[2] & (norm[3] | norm[1] | norm[0]);
        fr  = {1'b0, norm[9:3]} + {7'd0, rnd};
        if (fr[7]) e = e + 10'sd1;

        if (!norm[10])
            gen = BF16_PZERO;
        else if (e <= 10'sd0)
            gen = {big_s, 15'd0};
        else if (e > $signed(10'(2 * BF16_EXP_BIAS)))
            gen = big_s ? BF16_NINF : BF16_PINF;
        else
            gen = {big_s, e[7:0], fr[6:0]};

        if (a_nan || b_nan)
            sum = BF16_QNAN;
        else if (a_inf && b_inf)
            sum = (a[15] != b[15]) ? BF16_QNAN : a;
        else if (a_inf)
            sum = a;
        else if (b_inf)
            sum = b;
        else if (a_zero && b_zero)
            sum = {a[15] & b[15], 15'd0};
        else if (a_zero)
            sum = b;
        else if (b_zero)
            sum = a;
        else
            sum = gen;
    end

endmodule

// File: rtl/bf16_mac_seq.sv
// Dot-product sequencer: issues operand beats to an external bf16 tree and accumulates its partials.
// IDLE: wait for start | ISSUE: pass beats | DRAIN: wait for in-flight partials | OUT: hold result
module bf16_mac_seq
    import bf16_mac_seq_pkg::*;
#(
    parameter int TREE_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_beats,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [255:0]     op_data,
    output logic [255:0]     tree_in,
    input  logic [15:0]      tree_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data
);

    seq_state_t        state;
    logic [CNT_W-1:0]  beats_left;
    logic [TREE_LAT:0] vsr;
    logic [15:0]       acc;
    logic [15:0]       acc_sum;
    logic              fire;

    assign fire = op_valid & op_ready;

    bf16_add u_add (
        .a   (acc),
        .b   (tree_out),
        .sum (acc_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            beats_left <= '0;
            vsr        <= '0;
            acc        <= BF16_PZERO;
            busy       <= 1'b0;
            op_ready   <= 1'b0;
            tree_in    <= '0;
            res_valid  <= 1'b0;
            res_data   <= BF16_PZERO;
        end else begin
            // vsr[k] marks that tree_out will carry a real partial k cycles after issue
            vsr     <= {vsr[TREE_LAT-1:0], fire};
            tree_in <= fire ? op_data : '0;
            if (vsr[TREE_LAT]) acc <= acc_sum;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        beats_left <= num_beats;
                        acc        <= BF16_PZERO;
                        busy       <= 1'b1;
                        if (num_beats == '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            state    <= ST_ISSUE;
                            op_ready <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (fire) begin
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == CNT_W'(1)) begin
                            op_ready <= 1'b0;
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (vsr == '0) begin
                        state     <= ST_OUT;
                        res_valid <= 1'b1;
                        res_data  <= acc;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_mac_seq.sv
// Bench for bf16_mac_seq with a behavioural two-stage bf16 tree model on tree_in/tree_out.
module tb_bf16_mac_seq;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   num_beats = '0;
    logic         busy;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [255:0] op_data = '0;
    logic [255:0] tree_in;
    logic [15:0]  tree_out;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [15:0]  res_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    bf16_mac_seq #(.TREE_LAT(2), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_beats (num_beats),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .tree_in   (tree_in),
        .tree_out  (tree_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real bf2r(input logic [15:0] h);
        logic [63:0] bits;
        if (h[14:7] == 8'h00) return 0.0;
        if (h[14:7] == 8'hFF)
            bits = {h[15], 11'h7FF, (h[6:0] != 7'd0) ? 52'h8000000000000 : 52'h0};
        else
            bits = {h[15], 11'({3'b000, h[14:7]} + 11'd896), h[6:0], 45'd0};
        return $bitstoreal(bits);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] bits;
        int ne;
        bits = $realtobits(r);
        if (bits[62:52] == 11'h7FF) return (bits[51:0] != 52'd0) ? 16'h7FC0 : {bits[63], 15'h7F80};
        if (bits[62:52] == 11'h000) return 16'h0000;
        ne = int'(bits[62:52]) - 896;
        if (ne <= 0) return {bits[63], 15'd0};
        if (ne >= 255) return {bits[63], 15'h7F80};
        return {bits[63], 8'(ne), bits[51:45]};
    endfunction

    function automatic logic [15:0] tree_fn(input logic [255:0] v);
        real s;
        s = 0.0;
        for (int k = 0; k < 8; k++) s = s + bf2r(v[32*k +: 16]) * bf2r(v[32*k+16 +: 16]);
        return r2bf(s);
    endfunction

    logic [15:0] t1 = '0, t2 = '0;
    always @(posedge clk) begin
        t1 <= tree_fn(tree_in);
        t2 <= t1;
    end
    assign tree_out = t2;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [255:0] mk(input logic [15:0] a0, a1, a2, a3);
        logic [255:0] v;
        v = '0;
        v[15:0] = a0; v[31:16] = a1; v[47:32] = a2; v[63:48] = a3;
        return v;
    endfunction

    task automatic run_job(input int nb, input logic [2:0][255:0] beats, input int gap,
                           input int hold, output logic [15:0] res, output int lat);
        int e_acc;
        int w;
        e_acc = cyc;
        start = 1'b1;
        num_beats = 8'(nb);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            op_valid = 1'b1;
            op_data = beats[i];
            w = 0;
            while (!op_ready && w < 50) begin @(negedge clk); w++; end
            if (!op_ready) timeout_fail("op_ready wait");
            @(negedge clk);
            e_acc = cyc;
            op_valid = 1'b0;
            op_data = '0;
            chk("tree_in beat", tree_in, beats[i]);
            if (i < nb - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("tree_in bubble", tree_in, '0);
                end
            end
        end
        w = 0;
        while (!res_valid && w < 50) begin @(negedge clk); w++; end
        if (!res_valid) timeout_fail("res_valid wait");
        lat = cyc - e_acc;
        res = res_data;
        for (int h = 0; h < hold; h++) begin
            start = (h % 2 == 0);
            num_beats = 8'd1;
            @(negedge clk);
            chk("res_data hold", res_data, res);
            chk("res_valid hold", res_valid, 1);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]         nb;
        logic [2:0][255:0]  beat;
        logic [15:0]        expv;
    } vec_t;

    vec_t vecs [9];

    task automatic set_vec(input int i, input int nb, input logic [255:0] b0, b1, b2,
                           input logic [15:0] e);
        vecs[i].nb = 2'(nb);
        vecs[i].beat[0] = b0;
        vecs[i].beat[1] = b1;
        vecs[i].beat[2] = b2;
        vecs[i].expv = e;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] ba, bb, bc, bd, be, bf, bg, bi, bn, z;
        logic [2:0][255:0] bt;
        logic [15:0] res;
        int lat;
        bit ready_seen;

        z  = '0;
        ba = mk(16'h3F80, 16'h4000, 16'h4040, 16'h4080);  // 1*2 + 3*4 = 14
        bb = mk(16'h3F80, 16'h4000, 16'h0000, 16'h0000);  // 2
        bc = mk(16'hBF80, 16'h4180, 16'h0000, 16'h0000);  // -16
        bd = mk(16'hBF80, 16'h4000, 16'h0000, 16'h0000);  // -2
        be = mk(16'h3F80, 16'h3F80, 16'h0000, 16'h0000);  // 1
        bf = mk(16'h3B80, 16'h3F80, 16'h0000, 16'h0000);  // 2^-8
        bg = mk(16'h3F81, 16'h3F80, 16'h0000, 16'h0000);  // 1+2^-7
        bi = mk(16'h7F80, 16'h3F80, 16'h0000, 16'h0000);  // +inf
        bn = mk(16'hFF80, 16'h3F80, 16'h0000, 16'h0000);  // -inf

        set_vec(0, 1, ba, z,  z,  16'h4160);
        set_vec(1, 2, ba, bb, z,  16'h4180);
        set_vec(2, 2, ba, bc, z,  16'hC000);
        set_vec(3, 2, bb, bd, z,  16'h0000);
        set_vec(4, 2, be, bf, z,  16'h3F80);  // tie, even lsb stays
        set_vec(5, 2, bg, bf, z,  16'h3F82);  // tie, odd lsb rounds up
        set_vec(6, 2, bi, bn, z,  16'h7FC0);
        set_vec(7, 1, bi, z,  z,  16'h7F80);
        set_vec(8, 3, ba, ba, ba, 16'h4228);

        #2 reset = 1'b1;
        #1;
        chk("reset busy", busy, 0);
        chk("reset op_ready", op_ready, 0);
        chk("reset tree_in", tree_in, '0);
        chk("reset res_valid", res_valid, 0);
        chk("reset res_data", res_data, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_job(int'(vecs[i].nb), vecs[i].beat, 0, 0, res, lat);
            chk($sformatf("vec%0d res_data", i), res, vecs[i].expv);
            chk($sformatf("vec%0d latency", i), lat, 4);
            chk($sformatf("vec%0d busy after", i), busy, 0);
        end

        // 3-cycle op_valid bubble between the two beats
        bt[0] = ba; bt[1] = bb; bt[2] = z;
        run_job(2, bt, 3, 0, res, lat);
        chk("bubble res_data", res, 16'h4180);
        chk("bubble latency", lat, 4);

        // zero-beat job after a nonzero result
        ready_seen = 1'b0;
        start = 1'b1;
        num_beats = 8'd0;
        @(negedge clk);
        start = 1'b0;
        ready_seen = ready_seen | op_ready;
        chk("zero busy", busy, 1);
        chk("zero res_valid early", res_valid, 0);
        @(negedge clk);
        ready_seen = ready_seen | op_ready;
        chk("zero res_valid", res_valid, 1);
        chk("zero res_data", res_data, 16'h0000);
        chk("zero op_ready", ready_seen, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("zero busy after", busy, 0);

        // result held with res_ready low for 5 cycles, start pulses ignored
        bt[0] = ba; bt[1] = z; bt[2] = z;
        run_job(1, bt, 0, 5, res, lat);
        chk("hold res_data", res, 16'h4160);
        chk("hold busy after", busy, 0);
        chk("hold res_valid after", res_valid, 0);

        // reset in the middle of ISSUE
        start = 1'b1;
        num_beats = 8'd2;
        @(negedge clk);
        start = 1'b0;
        op_valid = 1'b1;
        op_data = ba;
        @(negedge clk);
        op_valid = 1'b0;
        op_data = '0;
        chk("pre-reset tree_in", tree_in, ba);
        reset = 1'b1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset op_ready", op_ready, 0);
        chk("midreset tree_in", tree_in, '0);
        chk("midreset res_valid", res_valid, 0);
        chk("midreset res_data", res_data, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bt[0] = bb; bt[1] = z; bt[2] = z;
        run_job(1, bt, 0, 0, res, lat);
        chk("post-reset res_data", res, 16'h4000);
        chk("post-reset latency", lat, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
